// File: rtl/dds_core.sv
// Direct digital synthesis data path: phase accumulator with wrap-aligned control shadows,
// sine/triangle/square synthesis, amplitude scaling and offset-binary conversion for a 12-bit DAC.
module dds_core #(
    parameter int ACC_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_en,
    input  logic [12:0] phase_M,
    input  logic [10:0] signal_A,
    input  logic [1:0]  signal_shape,
    output logic [11:0] dac_data,
    output logic        dac_valid,
    output logic        phase_wrap
);

    // Quarter-wave table: round(2047*sin(pi/2*(i+0.5)/64)), i = 0..63.
    localparam logic [10:0] SINE_Q [64] = '{
        11'd25,   11'd75,   11'd126,  11'd176,  11'd226,  11'd275,  11'd325,  11'd375,
        11'd424,  11'd473,  11'd522,  11'd570,  11'd618,  11'd666,  11'd713,  11'd760,
        11'd807,  11'd852,  11'd898,  11'd943,  11'd987,  11'd1031, 11'd1074, 11'd1116,
        11'd1158, 11'd1199, 11'd1239, 11'd1279, 11'd1318, 11'd1356, 11'd1393, 11'd1430,
        11'd1465, 11'd1500, 11'd1533, 11'd1566, 11'd1598, 11'd1629, 11'd1659, 11'd1688,
        11'd1716, 11'd1743, 11'd1769, 11'd1793, 11'd1817, 11'd1840, 11'd1861, 11'd1881,
        11'd1901, 11'd1919, 11'd1936, 11'd1951, 11'd1966, 11'd1979, 11'd1992, 11'd2003,
        11'd2012, 11'd2021, 11'd2028, 11'd2035, 11'd2039, 11'd2043, 11'd2046, 11'd2047
    };

    logic [ACC_W-1:0] acc;
    logic [12:0]      sh_m;
    logic [10:0]      sh_a;
    logic [1:0]       sh_shape;
    logic [ACC_W:0]   sum_cur;
    logic             load;
    logic [ACC_W-1:0] inc;

    // Shadows reload when the current step would overflow, or when no tuning word is active yet;
    // the freshly loaded word is the one applied on that same strobe.
    always_comb begin
        sum_cur = {1'b0, acc} + (ACC_W+1)'(sh_m);
        load    = sum_cur[ACC_W] || (sh_m == 13'd0);
        inc     = load ? ACC_W'(phase_M) : ACC_W'(sh_m);
    end

    logic v0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            sh_m       <= '0;
            sh_a       <= '0;
            sh_shape   <= '0;
            phase_wrap <= 1'b0;
            v0         <= 1'b0;
        end else begin
            v0         <= sample_en;
            phase_wrap <= sample_en && sum_cur[ACC_W];
            if (sample_en) begin
                acc <= acc + inc;
                if (load) begin
                    sh_m     <= phase_M;
                    sh_a     <= signal_A;
                    sh_shape <= signal_shape;
                end
            end
        end
    end

    logic [1:0]         quad;
    logic [5:0]         idx;
    logic [9:0]         r;
    logic [10:0]        sin_mag;
    logic [11:0]        tri_mag;
    logic signed [11:0] w_next;

    always_comb begin
        quad    = acc[ACC_W-1 -: 2];
        idx     = acc[ACC_W-3 -: 6];
        r       = acc[ACC_W-3 -: 10];
        sin_mag = SINE_Q[quad[0] ? ~idx : idx];
        tri_mag = quad[0] ? (12'd2047 - {1'b0, r, 1'b0}) : {1'b0, r, 1'b0};
        w_next  = '0;
        case (sh_shape)
            2'd0:    w_next = quad[1] ? -$signed({1'b0, sin_mag}) : $signed({1'b0, sin_mag});
            2'd1:    w_next = quad[1] ? -$signed(tri_mag) : $signed(tri_mag);
            2'd2:    w_next = acc[ACC_W-1] ? -12'sd2047 : 12'sd2047;
            default: w_next = '0;
        endcase
    end

    logic signed [11:0] w_q;
    logic [10:0]        a1;
    logic               v1;
    logic signed [23:0] mult;
    logic signed [22:0] prod;
    logic               v2;

    assign mult = $signed({{12{w_q[11]}}, w_q}) * $signed({13'd0, a1});

    // prod[22:11] is the floor of prod/2048; adding mid-scale gives the offset-binary code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q       <= '0;
            a1        <= '0;
            v1        <= 1'b0;
            prod      <= '0;
            v2        <= 1'b0;
            dac_data  <= 12'd2048;
            dac_valid <= 1'b0;
        end else begin
            w_q       <= w_next;
            a1        <= sh_a;
            v1        <= v0;
            prod      <= mult[22:0];
            v2        <= v1;
            dac_valid <= v2;
            if (v2) begin
                dac_data <= prod[22:11] + 12'h800;
            end
        end
    end

endmodule

// File: tb/tb_dds_core.sv
// Directed bench for dds_core: square, sine, triangle, retune at wrap, zero amplitude with
// gapped strobes, and asynchronous mid-stream reset.
module tb_dds_core;

    logic        clk;
    logic        rst;
    logic        sample_en;
    logic [12:0] phase_M;
    logic [10:0] signal_A;
    logic [1:0]  signal_shape;
    logic [11:0] dac_data;
    logic        dac_valid;
    logic        phase_wrap;

    int checks;
    int failures;
    int cyc;
    int out_q[$];
    int out_cyc_q[$];
    int wrap_q[$];
    int str_q[$];

    dds_core #(.ACC_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_en    (sample_en),
        .phase_M      (phase_M),
        .signal_A     (signal_A),
        .signal_shape (signal_shape),
        .dac_data     (dac_data),
        .dac_valid    (dac_valid),
        .phase_wrap   (phase_wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dac_valid) begin
            out_q.push_back(int'(dac_data));
            out_cyc_q.push_back(cyc);
        end
        if (phase_wrap) wrap_q.push_back(cyc);
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int out_at(input int k);
        return (k < out_q.size()) ? out_q[k] : -1;
    endfunction

    task automatic clear_q();
        out_q.delete();
        out_cyc_q.delete();
        wrap_q.delete();
        str_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sample_en = 1'b0;
        @(negedge clk);
        clear_q();
        rst = 1'b0;
    endtask

    task automatic set_in(input int m, input int a, input int shape);
        phase_M      = 13'(m);
        signal_A     = 11'(a);
        signal_shape = 2'(shape);
    endtask

    // Strobes n samples, leaving `gap` idle cycles after each one.
    task automatic run_strobes(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            sample_en = 1'b1;
            str_q.push_back(cyc + 1);
            @(negedge clk);
            sample_en = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic drain();
        sample_en = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        rst = 1'b1;
        sample_en = 1'b0;
        set_in(0, 0, 0);

        // Reset values.
        #1;
        check("rst_dac_data", int'(dac_data), 2048);
        check("rst_dac_valid", int'(dac_valid), 0);
        check("rst_phase_wrap", int'(phase_wrap), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_q();
        repeat (5) @(negedge clk);
        check("idle_no_valid", out_q.size(), 0);
        check("idle_dac_data", int'(dac_data), 2048);

        // Square, M=0x1000, A=2047: acc<0x8000 -> 2046+2048; else floor(-2047*2047/2048)=-2047 -> 1.
        do_reset();
        set_in(13'h1000, 2047, 2);
        run_strobes(16, 0);
        drain();
        check("sq_count", out_q.size(), 16);
        check("sq_first", out_at(0), 4094);
        check("sq_first_latency", out_cyc_q.size() > 0 ? out_cyc_q[0] - str_q[0] : -1, 3);
        check("sq_s7", out_at(6), 4094);
        check("sq_s8_neg", out_at(7), 1);
        check("sq_s15", out_at(14), 1);
        check("sq_s16_wrapped", out_at(15), 4094);
        check("sq_wrap_count", wrap_q.size(), 1);
        check("sq_wrap_cycle", wrap_q.size() > 0 ? wrap_q[0] : -1, str_q[15]);
        check("sq_hold", int'(dac_data), 4094);

        // Sine, M=0x1000, A=2047. q[0]=25, q[32]=1465, q[63]=2047.
        // acc 0x2000: 1465*2047>>11=1464 -> 3512; 0x4000: q[63] -> 2046 -> 4094;
        // 0x8000: -25*2047>>11=-25 -> 2023; 0xC000: -2047 -> 1; 0x0000: 24 -> 2072.
        do_reset();
        set_in(13'h1000, 2047, 0);
        run_strobes(16, 0);
        drain();
        check("sin_count", out_q.size(), 16);
        check("sin_acc2000", out_at(1), 3512);
        check("sin_acc4000", out_at(3), 4094);
        check("sin_acc8000", out_at(7), 2023);
        check("sin_accC000", out_at(11), 1);
        check("sin_acc0000", out_at(15), 2072);

        // Triangle, M=0x1000, A=1024: r=P[13:4].
        // 0x1000: 512*1024>>11=256 -> 2304; 0x2000: 2560; 0x5000: 1535 -> 767 -> 2815;
        // 0x9000: -512 -> -256 -> 1792; 0xD000: -1535 -> -768 -> 1280.
        do_reset();
        set_in(13'h1000, 1024, 1);
        run_strobes(13, 0);
        drain();
        check("tri_acc1000", out_at(0), 2304);
        check("tri_acc2000", out_at(1), 2560);
        check("tri_acc5000", out_at(4), 2815);
        check("tri_acc9000", out_at(8), 1792);
        check("tri_accD000", out_at(12), 1280);
        check("tri_hold", int'(dac_data), 1280);

        // Retune at acc=0x3000 to M=0x1800, shape off: steps stay 0x1000 until the wrap,
        // first post-wrap sample (acc 0xF000+0x1800=0x0800) is mid-scale.
        do_reset();
        set_in(13'h1000, 2047, 2);
        run_strobes(3, 0);
        set_in(13'h1800, 2047, 3);
        run_strobes(14, 0);
        drain();
        check("rt_count", out_q.size(), 17);
        check("rt_s4_old_shape", out_at(3), 4094);
        check("rt_s7_old_step", out_at(6), 4094);
        check("rt_s8_old_step", out_at(7), 1);
        check("rt_s15", out_at(14), 1);
        check("rt_s16_post_wrap", out_at(15), 2048);
        check("rt_s17", out_at(16), 2048);
        check("rt_wrap_count", wrap_q.size(), 1);
        check("rt_wrap_cycle", wrap_q.size() > 0 ? wrap_q[0] : -1, str_q[15]);

        // Zero amplitude, strobe every 4th cycle: one valid per strobe, 3-cycle latency.
        do_reset();
        set_in(13'h0700, 0, 1);
        run_strobes(6, 3);
        drain();
        check("gap_count", out_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check("gap_data", out_at(i), 2048);
            check("gap_latency", (i < out_cyc_q.size()) ? out_cyc_q[i] - str_q[i] : -1, 3);
        end

        // Asynchronous reset mid-stream, while a wrap pulse and a valid sample are live.
        do_reset();
        set_in(13'h1000, 2047, 2);
        run_strobes(16, 0);
        check("mid_pre_wrap", int'(phase_wrap), 1);
        check("mid_pre_valid", int'(dac_valid), 1);
        check("mid_pre_data", int'(dac_data), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_data", int'(dac_data), 2048);
        check("mid_rst_valid", int'(dac_valid), 0);
        check("mid_rst_wrap", int'(phase_wrap), 0);
        @(negedge clk);
        clear_q();
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_no_valid", out_q.size(), 0);
        check("post_rst_data", int'(dac_data), 2048);
        check("post_rst_no_wrap", wrap_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
